// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM states and buffer entry layout for the fetch stage
package fetch_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RESET_PC = 0;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] pc;
    } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer with flush and push+pop when full; head reads as 0 when empty
module fetch_fifo #(
    parameter int W = 42,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] head, tail, head_inc, tail_inc;
    assign head_inc = (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
    assign tail_inc = (tail == PW'(DEPTH - 1)) ? '0 : tail + 1'b1;
    assign dout = (count != '0) ? mem[head] : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail_inc;
            if (pop) head <= head_inc;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= din;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches one word per cycle into a buffer, handles redirect and halt-drain
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RESET_PC = DEF_RESET_PC,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_next,
    output logic              halted
);
    localparam int CW = $clog2(DEPTH + 1);
    state_t state, state_next;
    logic [ADDR_W-1:0] fpc;
    logic [CW-1:0] count;
    logic pop, push;
    assign imem_addr = fpc;
    assign out_valid = count != '0;
    assign pop = out_valid && out_ready;
    assign push = state == RUN && !redirect_valid && !halt_req && (count < CW'(DEPTH) || pop);
    assign out_pc_next = out_valid ? out_pc + 1'b1 : '0;
    assign halted = state == HALTED;
    fetch_fifo #(.W(DATA_W + ADDR_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .flush(redirect_valid),
        .din({imem_data, fpc}),
        .dout({out_instr, out_pc}),
        .count(count)
    );
    // DRAIN completes on the edge where the last entry leaves
    always_comb begin
        state_next = state;
        if (redirect_valid) state_next = RUN;
        else if (state == RUN && halt_req) state_next = DRAIN;
        else if (state == DRAIN && (count == '0 || (count == CW'(1) && pop))) state_next = HALTED;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            fpc <= ADDR_W'(RESET_PC);
        end else begin
            state <= state_next;
            fpc <= redirect_valid ? redirect_pc : push ? fpc + 1'b1 : fpc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of streaming, backpressure, redirect, wrap, halt and async reset
module tb_fetch_unit;
    logic clk = 0, rst_n = 0;
    logic [9:0] imem_addr, redirect_pc, out_pc, out_pc_next;
    logic [31:0] imem_data, out_instr;
    logic redirect_valid = 0, halt_req = 0, out_valid, out_ready = 1, halted;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign imem_data = 32'h1000 + {22'b0, imem_addr};

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_next(out_pc_next), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic head(input string tag, input logic [9:0] pc);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"}, 32'(out_pc), 32'(pc));
        chk({tag, "_instr"}, out_instr, 32'h1000 + 32'(pc));
        chk({tag, "_pcnext"}, 32'(out_pc_next), 32'(10'(pc + 10'd1)));
    endtask

    initial begin
        redirect_pc = '0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_pc", 32'(out_pc), 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pcnext", 32'(out_pc_next), 0);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            head("t1", 10'(i));
        end
        // backpressure from reset
        rst_n = 0;
        out_ready = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("t2_addr", 32'(imem_addr), 2);
        chk("t2_valid", 32'(out_valid), 1);
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            head("t2", 10'(i));
            if (i < 4) tick();
        end
        tick();
        head("t3_full", 10'd5);
        out_ready = 0;
        redirect_valid = 1;
        redirect_pc = 10'h200;
        tick();
        redirect_valid = 0;
        out_ready = 1;
        chk("t3_flush_valid", 32'(out_valid), 0);
        chk("t3_flush_addr", 32'(imem_addr), 32'h200);
        tick();
        head("t3a", 10'h200);
        tick();
        head("t3b", 10'h201);
        // redirect to the top of memory to exercise wrap
        redirect_valid = 1;
        redirect_pc = 10'h3FF;
        tick();
        redirect_valid = 0;
        chk("t4_flush_valid", 32'(out_valid), 0);
        tick();
        head("t4a", 10'h3FF);
        chk("t4_wrap_next", 32'(out_pc_next), 0);
        tick();
        head("t4b", 10'h000);
        out_ready = 0;
        tick();
        head("t5_buf", 10'h000);
        halt_req = 1;
        tick();
        halt_req = 0;
        out_ready = 1;
        chk("t5_drain_halted", 32'(halted), 0);
        chk("t5_drain_addr", 32'(imem_addr), 2);
        head("t5_d0", 10'h000);
        tick();
        head("t5_d1", 10'h001);
        tick();
        chk("t5_empty", 32'(out_valid), 0);
        chk("t5_halted", 32'(halted), 1);
        chk("t5_frozen", 32'(imem_addr), 2);
        tick();
        chk("t5_still_halted", 32'(halted), 1);
        chk("t5_still_frozen", 32'(imem_addr), 2);
        chk("t5_still_empty", 32'(out_valid), 0);
        redirect_valid = 1;
        redirect_pc = 10'h010;
        tick();
        redirect_valid = 0;
        chk("t5_resume_halted", 32'(halted), 0);
        chk("t5_resume_valid", 32'(out_valid), 0);
        tick();
        head("t5_resume", 10'h010);
        tick();
        head("t6_pre", 10'h011);
        #2 rst_n = 0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 0);
        chk("t6_async_halted", 32'(halted), 0);
        chk("t6_async_addr", 32'(imem_addr), 0);
        tick();
        chk("t6_held_valid", 32'(out_valid), 0);
        rst_n = 1;
        tick();
        head("t6a", 10'h000);
        tick();
        head("t6b", 10'h001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
